// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential restoring divider.
package div_pkg;

    localparam int DIV_N     = 3;
    localparam int DIV_CNT_W = $clog2(2 * DIV_N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Bit-counter width for a 2n-bit dividend.
    function automatic int div_cnt_w(input int n);
        return $clog2(2 * n);
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, subtract if it fits.
import div_pkg::*;

module div_step #(
    parameter int N = DIV_N
) (
    input  logic [N:0]   r_in,
    input  logic         d_bit,
    input  logic [N-1:0] divisor,
    output logic [N:0]   r_out,
    output logic         q_bit
);

    logic [N+1:0] r_wide;
    logic         fits;

    // Keep the full width so the compare is exact even if r_in carried a top bit.
    assign r_wide = {r_in, d_bit};
    assign fits   = (r_wide >= {2'b00, divisor});
    assign q_bit  = fits;
    assign r_out  = fits ? (N+1)'(r_wide - {2'b00, divisor}) : r_wide[N:0];

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// Optional quot_ovf output (quotient >= 2**N) is built when DIV_QUOT_OVF_EN is defined.
import div_pkg::*;

module seq_restoring_divider #(
    parameter int N = DIV_N
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] quotient,
    output logic [N-1:0]   remainder,
    output logic           div_by_zero
`ifdef DIV_QUOT_OVF_EN
    ,
    output logic           quot_ovf
`endif
);

    localparam int CW = div_cnt_w(N);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // in_ready is high only in IDLE, out_valid only in DONE, and DONE holds its outputs
    // until out_ready, so accept and result hand-off never share a cycle.

    div_state_e     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*N-1:0] dvd_q, dvd_d;
    logic [N-1:0]   dvs_q, dvs_d;
    logic [N:0]     r_q, r_d;
    logic [2*N-1:0] q_q, q_d;
    logic           dbz_q, dbz_d;
`ifdef DIV_QUOT_OVF_EN
    logic           ovf_q, ovf_d;
`endif

    logic [N:0] step_r;
    logic       step_q;

    div_step #(.N(N)) u_step (
        .r_in    (r_q),
        .d_bit   (dvd_q[cnt_q]),
        .divisor (dvs_q),
        .r_out   (step_r),
        .q_bit   (step_q)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        r_d     = r_q;
        q_d     = q_q;
        dbz_d   = dbz_q;
`ifdef DIV_QUOT_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dvd_d = dividend;
                    dvs_d = divisor;
                    r_d   = '0;
                    q_d   = '0;
                    dbz_d = 1'b0;
`ifdef DIV_QUOT_OVF_EN
                    ovf_d = 1'b0;
`endif
                    if (divisor == '0) begin
                        // Divide-by-zero skips the iterations entirely.
                        state_d = DONE;
                        q_d     = '1;
                        r_d     = {1'b0, dividend[N-1:0]};
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CW'(2 * N - 1);
                    end
                end
            end
            BUSY: begin
                r_d        = step_r;
                q_d[cnt_q] = step_q;
                cnt_d      = cnt_q - CW'(1);
`ifdef DIV_QUOT_OVF_EN
                ovf_d      = |q_d[2*N-1:N];
`endif
                if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dbz_q   <= dbz_d;
        end
    end

`ifdef DIV_QUOT_OVF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign quot_ovf = ovf_q;
`endif

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quotient    = q_q;
    assign remainder   = r_q[N-1:0];
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and randomised check of seq_restoring_divider (N=3) against hand-computed results.
module tb_seq_restoring_divider;

    localparam int N = 3;
    localparam int W = 2 * N + N + 2;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [2*N-1:0] dividend;
    logic [N-1:0]   divisor;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] quotient;
    logic [N-1:0]   remainder;
    logic           div_by_zero;
`ifdef DIV_QUOT_OVF_EN
    logic           quot_ovf;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] exp_q[$];

    seq_restoring_divider #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
`ifdef DIV_QUOT_OVF_EN
        ,
        .quot_ovf    (quot_ovf)
`endif
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] pack_exp(input logic [2*N-1:0] q, input logic [N-1:0] r,
                                              input logic dbz, input logic ovf);
        return {q, r, dbz, ovf};
    endfunction

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_in_ready"}, in_ready, 1);
        check_eq({tag, "_out_valid"}, out_valid, 0);
        check_eq({tag, "_quotient"}, quotient, 0);
        check_eq({tag, "_remainder"}, remainder, 0);
        check_eq({tag, "_dbz"}, div_by_zero, 0);
`ifdef DIV_QUOT_OVF_EN
        check_eq({tag, "_ovf"}, quot_ovf, 0);
`endif
    endtask

    // Scoreboard: compare the presented result with the head of exp_q, hold it for
    // `stall` cycles, then take it and confirm the return to IDLE.
    task automatic collect(input int stall, input bit watch_phantom);
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            check_eq("exp_q_empty", 0, 1);
            return;
        end
        e = exp_q.pop_front();
        check_eq("quotient", quotient, e[W-1:N+2]);
        check_eq("remainder", remainder, e[N+1:2]);
        check_eq("div_by_zero", div_by_zero, e[1]);
`ifdef DIV_QUOT_OVF_EN
        check_eq("quot_ovf", quot_ovf, e[0]);
`endif
        for (int s = 0; s < stall; s++) begin
            out_ready = 1'b0;
            @(posedge clk); #1;
            check_eq("hold_out_valid", out_valid, 1);
            check_eq("hold_in_ready", in_ready, 0);
            check_eq("hold_quotient", quotient, e[W-1:N+2]);
            check_eq("hold_remainder", remainder, e[N+1:2]);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq("after_take_out_valid", out_valid, 0);
        check_eq("after_take_in_ready", in_ready, 1);
        if (watch_phantom) begin
            @(posedge clk); #1;
            check_eq("no_phantom_op", out_valid, 0);
        end
    endtask

    // Driver: offer one operation, optionally poke in_valid while busy, then collect.
    task automatic apply_op(input logic [2*N-1:0] a, input logic [N-1:0] b,
                            input int exp_lat, input int stall, input bit junk);
        int w;
        int edges;
        w = 0;
        while (!in_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        check_eq("in_ready_before_accept", in_ready, 1);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        edges = 1;
        while (!out_valid && edges < 40) begin
            if (junk && edges >= 2 && edges <= 4) begin
                in_valid = 1'b1;
                dividend = 6'd63;
                divisor  = 3'd1;
                check_eq("in_ready_busy", in_ready, 0);
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            edges++;
        end
        check_eq("latency", edges, exp_lat);
        collect(stall, junk);
    endtask

    initial begin
        logic [2*N-1:0] ra;
        logic [N-1:0]   rb;
        logic [2*N-1:0] rq;
        logic [N-1:0]   rr;
        logic           rdbz;
        logic           rovf;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // 1) 35/5
        exp_q.push_back(pack_exp(6'd7, 3'd0, 1'b0, 1'b0));
        apply_op(6'd35, 3'd5, 7, 0, 1'b0);

        // 2) 17/3 then 63/7 (quotient 9 does not fit in N bits)
        exp_q.push_back(pack_exp(6'd5, 3'd2, 1'b0, 1'b0));
        apply_op(6'd17, 3'd3, 7, 0, 1'b0);
        exp_q.push_back(pack_exp(6'd9, 3'd0, 1'b0, 1'b1));
        apply_op(6'd63, 3'd7, 7, 1, 1'b0);

        // 3) 20/0
        exp_q.push_back(pack_exp(6'd63, 3'd4, 1'b1, 1'b0));
        apply_op(6'd20, 3'd0, 1, 0, 1'b0);

        // 4) backpressure and ignored in_valid while busy: 10/3
        exp_q.push_back(pack_exp(6'd3, 3'd1, 1'b0, 1'b0));
        apply_op(6'd10, 3'd3, 7, 5, 1'b1);

        // 5) reset in the middle of BUSY, after three steps
        dividend = 6'd40;
        divisor  = 3'd5;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_idle_outputs("midop_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("post_reset_out_valid", out_valid, 0);
        exp_q.push_back(pack_exp(6'd0, 3'd0, 1'b0, 1'b0));
        apply_op(6'd0, 3'd5, 7, 0, 1'b0);

        // 6) random operands with random output stalls
        for (int i = 0; i < 500; i++) begin
            ra = 6'($urandom_range(0, 63));
            rb = 3'($urandom_range(0, 7));
            if (rb == 3'd0) begin
                rq   = 6'd63;
                rr   = ra[N-1:0];
                rdbz = 1'b1;
                rovf = 1'b0;
            end else begin
                rq   = ra / {3'd0, rb};
                rr   = 3'(ra % {3'd0, rb});
                rdbz = 1'b0;
                rovf = (rq >= 6'd8);
            end
            exp_q.push_back(pack_exp(rq, rr, rdbz, rovf));
            apply_op(ra, rb, (rb == 3'd0) ? 1 : 7, int'($urandom_range(0, 3)), 1'b0);
        end

        check_eq("exp_q_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
